// File: rtl/bundler_seq_v3.sv
// Sequential majority bundler: accumulates per-bit ones counts over a group of
// hypervectors and emits the per-bit majority once the group closes.
module bundler_seq_v3 #(
  parameter int unsigned DIMENSIONS = 10000,
  parameter int unsigned NUM_HVS    = 5,
  parameter int unsigned TIE_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  input  logic [DIMENSIONS-1:0]            hv_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DIMENSIONS-1:0]            hvout,
  output logic [$clog2(NUM_HVS+1)-1:0]     hv_count
);

  localparam int unsigned CW = $clog2(NUM_HVS + 1);

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q [DIMENSIONS];
  logic [CW-1:0]         cnt_d [DIMENSIONS];
  logic [CW-1:0]         n_q;
  logic [CW-1:0]         n_inc;
  logic [DIMENSIONS-1:0] first_q;
  logic [DIMENSIONS-1:0] tie_src;
  logic [DIMENSIONS-1:0] tie_bits;
  logic [DIMENSIONS-1:0] maj;
  logic                  xfer;
  logic                  close;

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);

  // Counts including the vector on hv_in, and the majority they would produce
  // if this transfer closes the group.
  always_comb begin
    xfer    = in_valid && (state_q == StAccum);
    n_inc   = n_q + CW'(1);
    close   = xfer && (in_last || (n_inc == CW'(NUM_HVS)));
    // The first vector of a group is still on hv_in when n is zero.
    tie_src = (n_q == '0) ? hv_in : first_q;
    tie_bits = '0;
    maj      = '0;
    for (int unsigned d = 0; d < DIMENSIONS; d++) begin
      cnt_d[d] = cnt_q[d] + CW'(hv_in[d]);
      case (TIE_MODE)
        0:       tie_bits[d] = 1'b0;
        1:       tie_bits[d] = 1'b1;
        default: tie_bits[d] = tie_src[d];
      endcase
      // 2c vs N, both in CW+1 bits.
      if ({cnt_d[d], 1'b0} > {1'b0, n_inc}) begin
        maj[d] = 1'b1;
      end else if ({cnt_d[d], 1'b0} < {1'b0, n_inc}) begin
        maj[d] = 1'b0;
      end else begin
        maj[d] = tie_bits[d];
      end
    end
  end

  // Group FSM, counters and registered result; clear beats transfers and handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StAccum;
      n_q      <= '0;
      first_q  <= '0;
      hvout    <= '0;
      hv_count <= '0;
      for (int unsigned d = 0; d < DIMENSIONS; d++) begin
        cnt_q[d] <= '0;
      end
    end else if (clear) begin
      // hvout is deliberately kept; only the pending group/output is dropped.
      state_q <= StAccum;
      n_q     <= '0;
      first_q <= '0;
      for (int unsigned d = 0; d < DIMENSIONS; d++) begin
        cnt_q[d] <= '0;
      end
    end else if (state_q == StAccum) begin
      if (xfer) begin
        n_q <= n_inc;
        for (int unsigned d = 0; d < DIMENSIONS; d++) begin
          cnt_q[d] <= cnt_d[d];
        end
        if (n_q == '0) begin
          first_q <= hv_in;
        end
        if (close) begin
          state_q  <= StDone;
          hvout    <= maj;
          hv_count <= n_inc;
        end
      end
    end else if (out_ready) begin
      state_q <= StAccum;
      n_q     <= '0;
      first_q <= '0;
      for (int unsigned d = 0; d < DIMENSIONS; d++) begin
        cnt_q[d] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bundler_seq_v3.sv
// Bench for bundler_seq_v3: three instances (one per tie rule) share stimulus and
// are checked every cycle against a queue-based group model.
module tb_bundler_seq_v3;

  localparam int unsigned D  = 5;
  localparam int unsigned NH = 5;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [D-1:0]  hv_in = '0;
  logic          ir  [3];
  logic          ov  [3];
  logic [D-1:0]  hvo [3];
  logic [CW-1:0] hc  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bundler_seq_v3 #(
      .DIMENSIONS(D),
      .NUM_HVS   (NH),
      .TIE_MODE  (g)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .in_last  (in_last),
      .hv_in    (hv_in),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .hvout    (hvo[g]),
      .hv_count (hc[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_done = 1'b0;
  logic [D-1:0] grp [$];
  logic [D-1:0] m_exp [3];
  int           m_n = 0;

  function automatic logic [D-1:0] maj_of(input int mode);
    logic [D-1:0] r;
    int n;
    int c;
    r = '0;
    n = grp.size();
    for (int d = 0; d < D; d++) begin
      c = 0;
      foreach (grp[k]) c += int'(grp[k][d]);
      if (2 * c > n)      r[d] = 1'b1;
      else if (2 * c < n) r[d] = 1'b0;
      else                r[d] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : grp[0][d];
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_done = 1'b0;
      grp.delete();
      m_n = 0;
      for (int t = 0; t < 3; t++) m_exp[t] = '0;
    end else if (clear) begin
      m_done = 1'b0;
      grp.delete();
    end else if (!m_done) begin
      if (in_valid) begin
        grp.push_back(hv_in);
        if (in_last || grp.size() == NH) begin
          for (int t = 0; t < 3; t++) m_exp[t] = maj_of(t);
          m_n = grp.size();
          m_done = 1'b1;
        end
      end
    end else if (out_ready) begin
      m_done = 1'b0;
      grp.delete();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      if (!rst_n) begin
        check($sformatf("rst out_valid[%0d]", t), 32'(ov[t]), 32'(0));
        check($sformatf("rst in_ready[%0d]", t), 32'(ir[t]), 32'(1));
        check($sformatf("rst hv_count[%0d]", t), 32'(hc[t]), 32'(0));
        check($sformatf("rst hvout[%0d]", t), 32'(hvo[t]), 32'(0));
      end else begin
        check($sformatf("out_valid[%0d]", t), 32'(ov[t]), 32'(m_done));
        check($sformatf("in_ready[%0d]", t), 32'(ir[t]), 32'(!m_done));
        if (m_done) begin
          check($sformatf("hvout[%0d]", t), 32'(hvo[t]), 32'(m_exp[t]));
          check($sformatf("hv_count[%0d]", t), 32'(hc[t]), 32'(m_n));
        end
      end
    end
  end

  // ---------------- out_ready policy ----------------
  int stall_len = 0;
  int stall_cnt = 0;
  bit rnd_mode  = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    if (m_done) begin
      if (stall_cnt == 0 && rnd_mode) stall_len = $urandom_range(0, 4);
      out_ready = (stall_cnt >= stall_len);
      stall_cnt++;
    end else begin
      stall_cnt = 0;
      out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [D-1:0] v, input logic last, input int gap);
    bit acc;
    int budget;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_last  = 1'b1;  // must be ignored without in_valid
      hv_in    = D'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    hv_in    = v;
    in_last  = last;
    budget   = 0;
    acc      = 1'b0;
    do begin
      clear = rnd_mode && ($urandom_range(0, 24) == 0);
      @(negedge clk);
      acc = !m_done && !clear;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got not-accepted expected accepted");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [D-1:0] e0, input logic [D-1:0] e1,
                            input logic [D-1:0] e2, input int cnt);
    logic [D-1:0] e [3];
    int b;
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    b = 0;
    @(negedge clk);
    while (!m_done && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (!m_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no output expected output", name);
    end else begin
      for (int t = 0; t < 3; t++) begin
        check($sformatf("%s model[%0d]", name, t), 32'(m_exp[t]), 32'(e[t]));
        check($sformatf("%s hvout[%0d]", name, t), 32'(hvo[t]), 32'(e[t]));
        check($sformatf("%s hv_count[%0d]", name, t), 32'(hc[t]), 32'(cnt));
      end
    end
  endtask

  task automatic send_g1(input int gap);
    send(5'b01101, 1'b0, gap);
    send(5'b00111, 1'b0, gap);
    send(5'b01111, 1'b0, gap);
    send(5'b00011, 1'b0, gap);
    send(5'b00011, 1'b1, gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Odd group and an all-minority group.
    send_g1(0);
    expect_out("odd", 5'b00111, 5'b00111, 5'b00111, 5);
    send(5'b00010, 1'b0, 0);
    send(5'b00000, 1'b0, 0);
    send(5'b01000, 1'b0, 0);
    send(5'b00100, 1'b0, 0);
    send(5'b00100, 1'b1, 0);
    expect_out("zero", 5'b00000, 5'b00000, 5'b00000, 5);

    // Even group with a tie on bit 3.
    send(5'b01101, 1'b0, 0);
    send(5'b00111, 1'b0, 0);
    send(5'b01111, 1'b0, 0);
    send(5'b00011, 1'b1, 0);
    expect_out("even", 5'b00111, 5'b01111, 5'b01111, 4);

    // Auto-close; a following vector waits out the held output.
    stall_len = 3;
    send(5'b01101, 1'b0, 0);
    send(5'b00111, 1'b0, 0);
    send(5'b01111, 1'b0, 0);
    send(5'b00011, 1'b0, 0);
    send(5'b00011, 1'b0, 0);
    expect_out("auto", 5'b00111, 5'b00111, 5'b00111, 5);
    stall_len = 0;
    send(5'b10110, 1'b1, 0);
    expect_out("single", 5'b10110, 5'b10110, 5'b10110, 1);

    // Valid gaps and output backpressure.
    stall_len = 4;
    send_g1(1);
    expect_out("stall", 5'b00111, 5'b00111, 5'b00111, 5);
    stall_len = 0;

    // Abort a partial group.
    send(5'b11111, 1'b0, 0);
    send(5'b11111, 1'b0, 0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    send_g1(0);
    expect_out("clear", 5'b00111, 5'b00111, 5'b00111, 5);

    // Asynchronous reset mid-group.
    send(5'b11111, 1'b0, 0);
    send(5'b11111, 1'b0, 0);
    send(5'b11111, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int t = 0; t < 3; t++) begin
      check($sformatf("async out_valid[%0d]", t), 32'(ov[t]), 32'(0));
      check($sformatf("async in_ready[%0d]", t), 32'(ir[t]), 32'(1));
      check($sformatf("async hv_count[%0d]", t), 32'(hc[t]), 32'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_g1(0);
    expect_out("post_rst", 5'b00111, 5'b00111, 5'b00111, 5);

    // Randomized traffic with clears, gaps and backpressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      send(D'($urandom), 1'($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0) ? 1 : 0);
    end
    rnd_mode  = 1'b0;
    stall_len = 0;
    repeat (10) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
